frame_stream_source: RTL
========================

// Module: frame_stream_source
// PURPOSE
//  Reads one stored grayscale frame from a synchronous-read frame RAM and emits it as a
//  raster video stream (vsync/hsync/de/data). It is the producer that drives the edge-detection
//  filter chain, which consumes this stream pixel by pixel on de.
//  One frame is emitted per i_start request, with blanking, so downstream line buffers see
//  real line and frame boundaries.
// PARAMETERS
//  WIDTH   8    pixel data width
//  H_RES   80   active pixels per line
//  V_RES   60   active lines per frame
//  H_BLANK 16   horizontal blanking cycles per line (>=1)
//  V_BLANK 4    vertical blanking lines before active video (>=1)
//  ADDR_W  $clog2(H_RES*V_RES)  frame RAM address width (derived, do not override)
// PORTS
//  clk          in   1       clock
//  rst          in   1       reset, asynchronous, active-high
//  i_start      in   1       one-cycle frame request; ignored while o_busy=1
//  o_busy       out  1       high from the cycle after accepted i_start until o_done
//  o_done       out  1       one-cycle pulse at end of frame
//  o_rd_en      out  1       frame RAM read enable
//  o_rd_addr    out  ADDR_W  frame RAM read address, linear row*H_RES+col
//  i_rd_data    in   WIDTH   frame RAM read data, valid 1 cycle after o_rd_en
//  o_vsync      out  1       high during vertical blanking lines
//  o_hsync      out  1       high during the H_BLANK cycles of every line
//  o_de         out  1       high for each active pixel
//  o_data       out  WIDTH   pixel value; 0 when o_de=0
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, counters 0. Asserting rst mid-frame aborts at once; no o_done.
//  - Line = H_RES+H_BLANK cycles: H_RES "active slot" cycles, then H_BLANK hsync cycles.
//  - FSM: IDLE -(i_start)-> VBLANK -(V_BLANK lines done)-> ACTIVE -(V_RES lines done)-> DONE -> IDLE.
//  - VBLANK: vsync_int=1 on all cycles of the line, hsync_int=1 in blank slots, de_int=0, no RAM reads.
//  - ACTIVE: de_int=1 and o_rd_en=1 in active slots; hsync_int=1 in blank slots; vsync_int=0.
//  - Address: starts at 0 on accepted i_start; increments on each o_rd_en; last address H_RES*V_RES-1;
//    returns to 0 in DONE.
//  - Alignment: RAM has 1-cycle read latency. o_vsync/o_hsync/o_de are the *_int signals delayed
//    1 register stage; o_data=i_rd_data registered with the same alignment.
//    o_de rises exactly 1 cycle after the o_rd_en of the same pixel.
//  - DONE is 1 cycle: o_done=1, o_busy falls the same cycle, and all stream outputs are 0.
//    It follows the last hsync output cycle of the final line.
//  - i_start asserted in the DONE cycle is ignored. i_start in IDLE is accepted the following cycle.
//  - Frame length from accepted i_start to o_done: (V_BLANK+V_RES)*(H_RES+H_BLANK)+1 cycles.
// CONFIGURATION
//  - FSP_TEST_PATTERN_EN defined: adds input i_pattern_sel (1 bit, sampled at frame start).
//    When 1: o_rd_en stays 0, and o_data=(col+row) truncated to WIDTH, with identical sync timing.
//    When 0: normal RAM path.
//  - FSP_TEST_PATTERN_EN undefined: port absent, RAM path only.
// STRUCTURE
//  - Package frame_stream_pkg: state_t enum {IDLE,VBLANK,ACTIVE,DONE} and the frame-length
//    helper function.
//  - Sub-module video_timing_counter: column/line counters with slot/line-end flags; FSM and
//    output registers stay in the top module.
// TESTING (H_RES=4, V_RES=3, H_BLANK=2, V_BLANK=1, WIDTH=8; RAM preloaded addr*10)
//  - Reset, then idle 20 cycles -> all outputs 0, no o_rd_en.
//  - i_start pulse -> 6 cycles vsync=1 (hsync=1 on last 2 of them); then 3 lines of
//    de=1 for 4 cycles / hsync=1 for 2.
//    o_data sequence 0,10,...,110; o_done 25 cycles after start.
//  - i_start held high for whole frame -> exactly one frame; o_busy low 1 cycle minimum between frames.
//  - rst asserted at the 2nd pixel of line 1 -> outputs 0 immediately, no o_done.
//    Next i_start re-reads from addr 0.
//  - Every cycle: o_de(t)==o_rd_en(t-1), and o_data==0 whenever o_de=0.
//  - With FSP_TEST_PATTERN_EN, i_pattern_sel=1 -> o_rd_en never 1.
//    Line 2 o_data = 2,3,4,5; timing identical to RAM case.

Source files
------------

// File: rtl/frame_stream_pkg.sv
// Shared types and helpers for the frame stream source.
package frame_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VBLANK = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Cycles from an accepted start request to the o_done pulse.
  function automatic int unsigned frame_len(input int unsigned h_res,
                                            input int unsigned v_res,
                                            input int unsigned h_blank,
                                            input int unsigned v_blank);
    return (v_blank + v_res) * (h_res + h_blank) + 1;
  endfunction

endpackage

// File: rtl/frame_stream_source_timing.sv
// Column/line counters for the raster scan, with slot and line/frame boundary flags.
module video_timing_counter #(
  parameter int unsigned H_RES   = 80,
  parameter int unsigned V_RES   = 60,
  parameter int unsigned H_BLANK = 16,
  parameter int unsigned V_BLANK = 4,
  localparam int unsigned COL_W  = $clog2(H_RES + H_BLANK),
  localparam int unsigned LINE_W = $clog2(V_BLANK + V_RES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [COL_W-1:0]  o_col,
  output logic [LINE_W-1:0] o_row,
  output logic              o_active_slot,
  output logic              o_line_end,
  output logic              o_vblank_end,
  output logic              o_frame_end
);

  localparam logic [COL_W-1:0]  ColLast  = COL_W'(H_RES + H_BLANK - 1);
  localparam logic [LINE_W-1:0] LineLast = LINE_W'(V_BLANK + V_RES - 1);
  localparam logic [LINE_W-1:0] VbLast   = LINE_W'(V_BLANK - 1);

  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      line_q <= '0;
    end else begin
      col_q  <= col_d;
      line_q <= line_d;
    end
  end

  assign o_line_end    = (col_q == ColLast);
  assign o_active_slot = (col_q < COL_W'(H_RES));
  assign o_vblank_end  = o_line_end && (line_q == VbLast);
  assign o_frame_end   = o_line_end && (line_q == LineLast);
  assign o_col         = col_q;
  // Row index within active video; 0 during vertical blanking.
  assign o_row         = (line_q < LINE_W'(V_BLANK)) ? '0 : line_q - LINE_W'(V_BLANK);

  always_comb begin
    col_d  = col_q;
    line_d = line_q;
    if (i_clr) begin
      col_d  = '0;
      line_d = '0;
    end else if (i_en) begin
      if (o_line_end) begin
        col_d  = '0;
        line_d = (line_q == LineLast) ? '0 : line_q + LINE_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/frame_stream_source.sv
// Emits one stored frame as a raster stream per i_start request.
// Optional test pattern source enabled by defining FSP_TEST_PATTERN_EN.
module frame_stream_source
  import frame_stream_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned H_RES   = 80,
  parameter int unsigned V_RES   = 60,
  parameter int unsigned H_BLANK = 16,
  parameter int unsigned V_BLANK = 4,
  localparam int unsigned ADDR_W = $clog2(H_RES * V_RES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
`ifdef FSP_TEST_PATTERN_EN
  input  logic              i_pattern_sel,
`endif
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [WIDTH-1:0]  i_rd_data,
  output logic              o_vsync,
  output logic              o_hsync,
  output logic              o_de,
  output logic [WIDTH-1:0]  o_data
);

  localparam int unsigned COL_W  = $clog2(H_RES + H_BLANK);
  localparam int unsigned LINE_W = $clog2(V_BLANK + V_RES);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               vsync_q, vsync_d;
  logic               hsync_q, hsync_d;
  logic               de_q, de_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pat_sel_q, pat_sel_d;
  logic [WIDTH-1:0]   pat_data_q, pat_data_d;

  logic               run;
  logic               start_acc;
  logic               rd_en;
  logic [COL_W-1:0]   col;
  logic [LINE_W-1:0]  row;
  logic               active_slot, line_end, vblank_end, frame_end;

  assign run = (state_q == VBLANK) || (state_q == ACTIVE);

  video_timing_counter #(
    .H_RES   (H_RES),
    .V_RES   (V_RES),
    .H_BLANK (H_BLANK),
    .V_BLANK (V_BLANK)
  ) u_timing (
    .clk           (clk),
    .rst           (rst),
    .i_clr         (!run),
    .i_en          (run),
    .o_col         (col),
    .o_row         (row),
    .o_active_slot (active_slot),
    .o_line_end    (line_end),
    .o_vblank_end  (vblank_end),
    .o_frame_end   (frame_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      vsync_q    <= 1'b0;
      hsync_q    <= 1'b0;
      de_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pat_sel_q  <= 1'b0;
      pat_data_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      vsync_q    <= vsync_d;
      hsync_q    <= hsync_d;
      de_q       <= de_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pat_sel_q  <= pat_sel_d;
      pat_data_q <= pat_data_d;
    end
  end

  // A request landing on the o_done cycle is dropped, guaranteeing a busy-low gap.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start && !done_q) begin
          state_d   = VBLANK;
          start_acc = 1'b1;
        end
      end
      VBLANK:  if (vblank_end) state_d = ACTIVE;
      ACTIVE:  if (frame_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vsync_d    = (state_q == VBLANK);
    hsync_d    = run && !active_slot;
    de_d       = (state_q == ACTIVE) && active_slot;
    busy_d     = run;
    done_d     = (state_q == DONE);
    rd_en      = de_d && !pat_sel_q;
    pat_data_d = de_d ? WIDTH'(int'(col) + int'(row)) : '0;

    addr_d = addr_q;
    if (start_acc || (state_q == DONE)) begin
      addr_d = '0;
    end else if (rd_en) begin
      addr_d = addr_q + ADDR_W'(1);
    end

`ifdef FSP_TEST_PATTERN_EN
    pat_sel_d = start_acc ? i_pattern_sel : pat_sel_q;
`else
    pat_sel_d = 1'b0;
`endif
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_rd_en   = rd_en;
  assign o_rd_addr = addr_q;
  assign o_vsync   = vsync_q;
  assign o_hsync   = hsync_q;
  assign o_de      = de_q;
  // RAM data arrives one cycle after the read, aligned with o_de.
  assign o_data    = de_q ? (pat_sel_q ? pat_data_q : i_rd_data) : '0;

endmodule
